// File: rtl/osd_scm_rstctl.sv
`timescale 1ns/1ps
// osd_scm_rstctl
// -------------------------------------------------------------------------
// Subnet control module for the debug system. It answers the register
// backend bus of an osd_regaccess instance with a single-cycle,
// combinational handshake. It exposes the static system-description values
// and drives NUM_RST independent reset domains. Each domain can be held in
// reset by a level bit or pulsed for a programmable number of cycles.
//
// Parameters
//   SYSTEMID       system identifier, low 16 bit readable at 0x200
//   NUM_MOD        number of debug modules, low 16 bit readable at 0x201
//   MAX_PKT_LEN    maximum debug packet length in flits, 0x202
//   NUM_RST        number of reset domains (1..16), 0x206
//   PULSE_DEFAULT  reset value of the pulse length register (0..65535)
//
// Ports
//   clk          clock
//   rst          synchronous active-high reset
//   reg_request  register access valid
//   reg_write    1 = write, 0 = read
//   reg_addr     register address
//   reg_size     access size (unused, all registers are 16 bit)
//   reg_wdata    write data
//   reg_ack      access accepted, same cycle as reg_request
//   reg_err      access error, only together with reg_ack
//   reg_rdata    read data, valid with reg_ack on reads
//   rst_out      per-domain reset, active-high
// -------------------------------------------------------------------------
module osd_scm_rstctl #(
    parameter logic [31:0] SYSTEMID      = 32'h0,
    parameter logic [31:0] NUM_MOD       = 32'h0,
    parameter int unsigned MAX_PKT_LEN   = 8,
    parameter int unsigned NUM_RST       = 2,
    parameter int unsigned PULSE_DEFAULT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               reg_request,
    input  logic               reg_write,
    input  logic [15:0]        reg_addr,
    input  logic [1:0]         reg_size,
    input  logic [15:0]        reg_wdata,
    output logic               reg_ack,
    output logic               reg_err,
    output logic [15:0]        reg_rdata,
    output logic [NUM_RST-1:0] rst_out
);

    localparam logic [15:0] ADDR_SYSTEMID  = 16'h0200;
    localparam logic [15:0] ADDR_NUM_MOD   = 16'h0201;
    localparam logic [15:0] ADDR_MAX_PKT   = 16'h0202;
    localparam logic [15:0] ADDR_RST_LEVEL = 16'h0203;
    localparam logic [15:0] ADDR_RST_PULSE = 16'h0204;
    localparam logic [15:0] ADDR_PULSE_LEN = 16'h0205;
    localparam logic [15:0] ADDR_NUM_RST   = 16'h0206;
    localparam logic [15:0] ADDR_RST_COUNT = 16'h0207;

    localparam logic [15:0] SYSTEMID_VAL  = SYSTEMID[15:0];
    localparam logic [15:0] NUM_MOD_VAL   = NUM_MOD[15:0];
    localparam logic [15:0] MAX_PKT_VAL   = 16'(MAX_PKT_LEN);
    localparam logic [15:0] NUM_RST_VAL   = 16'(NUM_RST);
    localparam logic [15:0] PULSE_DEF_VAL = 16'(PULSE_DEFAULT);

    logic [NUM_RST-1:0] level;
    logic [NUM_RST-1:0] pulse_mask;
    logic [15:0]        cnt;
    logic [15:0]        rst_count;
    logic [15:0]        pulse_len;

    logic               addr_mapped;
    logic               addr_read_only;
    logic               wr_en;
    logic [NUM_RST-1:0] pulse_data;
    logic               trigger;
    logic [15:0]        pulse_load;

    // The access size carries no information here; folding it into a
    // dedicated net keeps it visibly consumed.
    logic unused_size;
    assign unused_size = ^reg_size;

    // Address decode: which addresses exist and which of them are read-only.
    always_comb begin
        addr_mapped    = 1'b0;
        addr_read_only = 1'b0;
        case (reg_addr)
            ADDR_SYSTEMID, ADDR_NUM_MOD, ADDR_MAX_PKT, ADDR_NUM_RST: begin
                addr_mapped    = 1'b1;
                addr_read_only = 1'b1;
            end
            ADDR_RST_LEVEL, ADDR_RST_PULSE, ADDR_PULSE_LEN, ADDR_RST_COUNT: begin
                addr_mapped = 1'b1;
            end
            default: begin
                addr_mapped    = 1'b0;
                addr_read_only = 1'b0;
            end
        endcase
    end

    assign reg_ack = reg_request;
    assign reg_err = reg_request & (~addr_mapped | (reg_write & addr_read_only));

    // Errored writes never reach wr_en, so they cannot change any state.
    assign wr_en      = reg_request & reg_write & addr_mapped & ~addr_read_only;
    assign pulse_data = reg_wdata[NUM_RST-1:0];
    assign trigger    = wr_en & (reg_addr == ADDR_RST_PULSE) & (|pulse_data);
    assign pulse_load = (pulse_len == 16'd0) ? 16'd1 : pulse_len;

    // Register state and the pulse engine. A trigger reloads the shared
    // counter, which stretches every active pulse to end L cycles after the
    // latest trigger. The mask clears on the same edge the counter leaves 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            level      <= '0;
            pulse_mask <= '0;
            cnt        <= 16'd0;
            rst_count  <= 16'd0;
            pulse_len  <= PULSE_DEF_VAL;
        end else begin
            if (wr_en && reg_addr == ADDR_RST_LEVEL) begin
                level <= pulse_data;
            end
            if (wr_en && reg_addr == ADDR_PULSE_LEN) begin
                pulse_len <= reg_wdata;
            end
            if (trigger) begin
                pulse_mask <= pulse_mask | pulse_data;
                cnt        <= pulse_load;
                if (rst_count != 16'hFFFF) begin
                    rst_count <= rst_count + 16'd1;
                end
            end else if (cnt != 16'd0) begin
                cnt <= cnt - 16'd1;
                if (cnt == 16'd1) begin
                    pulse_mask <= '0;
                end
            end
            if (wr_en && reg_addr == ADDR_RST_COUNT) begin
                rst_count <= 16'd0;
            end
        end
    end

    // Read mux; values narrower than 16 bit are zero-extended.
    always_comb begin
        reg_rdata = 16'h0000;
        case (reg_addr)
            ADDR_SYSTEMID:  reg_rdata = SYSTEMID_VAL;
            ADDR_NUM_MOD:   reg_rdata = NUM_MOD_VAL;
            ADDR_MAX_PKT:   reg_rdata = MAX_PKT_VAL;
            ADDR_RST_LEVEL: reg_rdata = 16'(level);
            ADDR_RST_PULSE: reg_rdata = 16'(pulse_mask);
            ADDR_PULSE_LEN: reg_rdata = pulse_len;
            ADDR_NUM_RST:   reg_rdata = NUM_RST_VAL;
            ADDR_RST_COUNT: reg_rdata = rst_count;
            default:        reg_rdata = 16'h0000;
        endcase
    end

    // Only registered state and rst feed rst_out, so each domain is glitch-free.
    assign rst_out = {NUM_RST{rst}} | level | pulse_mask;

endmodule

// File: tb/tb_osd_scm_rstctl.sv
`timescale 1ns/1ps
// tb_osd_scm_rstctl
// -------------------------------------------------------------------------
// Directed self-checking bench for osd_scm_rstctl with NUM_RST = 2.
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge. Each task covers one feature and checks its own results.
// -------------------------------------------------------------------------
module tb_osd_scm_rstctl;

    localparam logic [31:0] P_SYSTEMID = 32'h1234ABCD;
    localparam logic [31:0] P_NUM_MOD  = 32'h00010005;

    logic        clk;
    logic        rst;
    logic        reg_request;
    logic        reg_write;
    logic [15:0] reg_addr;
    logic [1:0]  reg_size;
    logic [15:0] reg_wdata;
    logic        reg_ack;
    logic        reg_err;
    logic [15:0] reg_rdata;
    logic [1:0]  rst_out;

    int nvec = 0;
    int nerr = 0;

    osd_scm_rstctl #(
        .SYSTEMID      (P_SYSTEMID),
        .NUM_MOD       (P_NUM_MOD),
        .MAX_PKT_LEN   (8),
        .NUM_RST       (2),
        .PULSE_DEFAULT (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .reg_request (reg_request),
        .reg_write   (reg_write),
        .reg_addr    (reg_addr),
        .reg_size    (reg_size),
        .reg_wdata   (reg_wdata),
        .reg_ack     (reg_ack),
        .reg_err     (reg_err),
        .reg_rdata   (reg_rdata),
        .rst_out     (rst_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One bus access lasting one clock cycle; returns what the DUT showed
    // at the falling edge of that cycle.
    task automatic bus(input logic wr, input logic [15:0] addr, input logic [15:0] wd,
                       output logic ack, output logic err, output logic [15:0] rd,
                       output logic [1:0] ro);
        reg_request = 1'b1;
        reg_write   = wr;
        reg_addr    = addr;
        reg_wdata   = wd;
        reg_size    = 2'b01;
        @(negedge clk);
        ack = reg_ack;
        err = reg_err;
        rd  = reg_rdata;
        ro  = rst_out;
        @(posedge clk);
        #1;
        reg_request = 1'b0;
        reg_write   = 1'b0;
        reg_addr    = 16'h0000;
        reg_wdata   = 16'h0000;
    endtask

    // One idle cycle; returns rst_out at the falling edge.
    task automatic idle(output logic [1:0] ro);
        @(negedge clk);
        ro = rst_out;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic ack, err;
        logic [15:0] rd;
        logic [1:0] ro;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bus(1'b0, 16'h0200, 16'h0000, ack, err, rd, ro);
        nvec++; if (ro !== 2'b11) begin nerr++; $display("[TB] FAIL rst_out_in_reset: got %b expected %b", ro, 2'b11); end
        nvec++; if (ack !== 1'b1) begin nerr++; $display("[TB] FAIL ack_in_reset: got %b expected %b", ack, 1'b1); end
        rst = 1'b0;
        bus(1'b0, 16'h0200, 16'h0000, ack, err, rd, ro);
        nvec++; if (rd !== 16'hABCD) begin nerr++; $display("[TB] FAIL rd_systemid: got %h expected %h", rd, 16'hABCD); end
        nvec++; if (err !== 1'b0) begin nerr++; $display("[TB] FAIL err_systemid: got %b expected %b", err, 1'b0); end
        nvec++; if (ro !== 2'b00) begin nerr++; $display("[TB] FAIL rst_out_after_reset: got %b expected %b", ro, 2'b00); end
        bus(1'b0, 16'h0201, 16'h0000, ack, err, rd, ro);
        nvec++; if (rd !== 16'h0005) begin nerr++; $display("[TB] FAIL rd_num_mod: got %h expected %h", rd, 16'h0005); end
        nvec++; if (err !== 1'b0) begin nerr++; $display("[TB] FAIL err_num_mod: got %b expected %b", err, 1'b0); end
        bus(1'b0, 16'h0202, 16'h0000, ack, err, rd, ro);
        nvec++; if (rd !== 16'h0008) begin nerr++; $display("[TB] FAIL rd_max_pkt: got %h expected %h", rd, 16'h0008); end
        bus(1'b0, 16'h0206, 16'h0000, ack, err, rd, ro);
        nvec++; if (rd !== 16'h0002) begin nerr++; $display("[TB] FAIL rd_num_rst: got %h expected %h", rd, 16'h0002); end
        nvec++; if (err !== 1'b0) begin nerr++; $display("[TB] FAIL err_num_rst: got %b expected %b", err, 1'b0); end
        bus(1'b0, 16'h0205, 16'h0000, ack, err, rd, ro);
        nvec++; if (rd !== 16'h0010) begin nerr++; $display("[TB] FAIL rd_pulse_len_default: got %h expected %h", rd, 16'h0010); end
        bus(1'b0, 16'h0207, 16'h0000, ack, err, rd, ro);
        nvec++; if (rd !== 16'h0000) begin nerr++; $display("[TB] FAIL rd_count_reset: got %h expected %h", rd, 16'h0000); end
    endtask

    task automatic test_level;
        logic ack, err;
        logic [15:0] rd;
        logic [1:0] ro;
        bus(1'b1, 16'h0203, 16'hFFFF, ack, err, rd, ro);
        nvec++; if (err !== 1'b0) begin nerr++; $display("[TB] FAIL err_level_write: got %b expected %b", err, 1'b0); end
        idle(ro);
        nvec++; if (ro !== 2'b11) begin nerr++; $display("[TB] FAIL rst_out_level_set: got %b expected %b", ro, 2'b11); end
        bus(1'b0, 16'h0203, 16'h0000, ack, err, rd, ro);
        nvec++; if (rd !== 16'h0003) begin nerr++; $display("[TB] FAIL rd_level: got %h expected %h", rd, 16'h0003); end
        bus(1'b1, 16'h0203, 16'h0002, ack, err, rd, ro);
        idle(ro);
        nvec++; if (ro !== 2'b10) begin nerr++; $display("[TB] FAIL rst_out_level_bit1: got %b expected %b", ro, 2'b10); end
        bus(1'b1, 16'h0203, 16'h0000, ack, err, rd, ro);
        idle(ro);
        nvec++; if (ro !== 2'b00) begin nerr++; $display("[TB] FAIL rst_out_level_clear: got %b expected %b", ro, 2'b00); end
    endtask

    task automatic test_pulse;
        logic ack, err;
        logic [15:0] rd;
        logic [1:0] ro;
        logic [1:0] exp;
        bus(1'b1, 16'h0205, 16'h0005, ack, err, rd, ro);
        bus(1'b1, 16'h0204, 16'h0002, ack, err, rd, ro);
        nvec++; if (ro !== 2'b00) begin nerr++; $display("[TB] FAIL rst_out_before_pulse_edge: got %b expected %b", ro, 2'b00); end
        // cycle 0 of the pulse
        bus(1'b0, 16'h0204, 16'h0000, ack, err, rd, ro);
        nvec++; if (rd !== 16'h0002) begin nerr++; $display("[TB] FAIL rd_pulse_mask: got %h expected %h", rd, 16'h0002); end
        nvec++; if (ro !== 2'b10) begin nerr++; $display("[TB] FAIL rst_out_pulse_c0: got %b expected %b", ro, 2'b10); end
        // cycle 1
        bus(1'b0, 16'h0207, 16'h0000, ack, err, rd, ro);
        nvec++; if (rd !== 16'h0001) begin nerr++; $display("[TB] FAIL rd_count_one: got %h expected %h", rd, 16'h0001); end
        nvec++; if (ro !== 2'b10) begin nerr++; $display("[TB] FAIL rst_out_pulse_c1: got %b expected %b", ro, 2'b10); end
        for (int k = 2; k < 8; k++) begin
            idle(ro);
            exp = (k < 5) ? 2'b10 : 2'b00;
            nvec++; if (ro !== exp) begin nerr++; $display("[TB] FAIL rst_out_pulse_c%0d: got %b expected %b", k, ro, exp); end
        end
        bus(1'b0, 16'h0204, 16'h0000, ack, err, rd, ro);
        nvec++; if (rd !== 16'h0000) begin nerr++; $display("[TB] FAIL rd_pulse_mask_done: got %h expected %h", rd, 16'h0000); end
    endtask

    task automatic test_retrigger;
        logic ack, err;
        logic [15:0] rd;
        logic [1:0] ro;
        logic [1:0] exp;
        bus(1'b1, 16'h0207, 16'h1234, ack, err, rd, ro);
        bus(1'b1, 16'h0205, 16'd10, ack, err, rd, ro);
        bus(1'b1, 16'h0204, 16'h0001, ack, err, rd, ro);
        for (int k = 0; k < 3; k++) begin
            idle(ro);
            nvec++; if (ro !== 2'b01) begin nerr++; $display("[TB] FAIL rst_out_first_c%0d: got %b expected %b", k, ro, 2'b01); end
        end
        bus(1'b1, 16'h0204, 16'h0002, ack, err, rd, ro);
        nvec++; if (ro !== 2'b01) begin nerr++; $display("[TB] FAIL rst_out_first_c3: got %b expected %b", ro, 2'b01); end
        for (int k = 0; k < 12; k++) begin
            idle(ro);
            exp = (k < 10) ? 2'b11 : 2'b00;
            nvec++; if (ro !== exp) begin nerr++; $display("[TB] FAIL rst_out_retrig_c%0d: got %b expected %b", k, ro, exp); end
        end
        bus(1'b0, 16'h0207, 16'h0000, ack, err, rd, ro);
        nvec++; if (rd !== 16'h0002) begin nerr++; $display("[TB] FAIL rd_count_retrig: got %h expected %h", rd, 16'h0002); end
    endtask

    task automatic test_zero_length;
        logic ack, err;
        logic [15:0] rd;
        logic [1:0] ro;
        bus(1'b1, 16'h0205, 16'h0000, ack, err, rd, ro);
        bus(1'b0, 16'h0205, 16'h0000, ack, err, rd, ro);
        nvec++; if (rd !== 16'h0000) begin nerr++; $display("[TB] FAIL rd_pulse_len_zero: got %h expected %h", rd, 16'h0000); end
        bus(1'b1, 16'h0204, 16'h0001, ack, err, rd, ro);
        idle(ro);
        nvec++; if (ro !== 2'b01) begin nerr++; $display("[TB] FAIL rst_out_zero_len_c0: got %b expected %b", ro, 2'b01); end
        idle(ro);
        nvec++; if (ro !== 2'b00) begin nerr++; $display("[TB] FAIL rst_out_zero_len_c1: got %b expected %b", ro, 2'b00); end
    endtask

    task automatic test_level_over_pulse;
        logic ack, err;
        logic [15:0] rd;
        logic [1:0] ro;
        bus(1'b1, 16'h0203, 16'h0001, ack, err, rd, ro);
        bus(1'b1, 16'h0205, 16'h0002, ack, err, rd, ro);
        bus(1'b1, 16'h0204, 16'h0001, ack, err, rd, ro);
        for (int k = 0; k < 4; k++) begin
            idle(ro);
            nvec++; if (ro !== 2'b01) begin nerr++; $display("[TB] FAIL rst_out_level_hold_c%0d: got %b expected %b", k, ro, 2'b01); end
        end
        bus(1'b0, 16'h0204, 16'h0000, ack, err, rd, ro);
        nvec++; if (rd !== 16'h0000) begin nerr++; $display("[TB] FAIL rd_pulse_expired: got %h expected %h", rd, 16'h0000); end
        bus(1'b1, 16'h0203, 16'h0000, ack, err, rd, ro);
        idle(ro);
        nvec++; if (ro !== 2'b00) begin nerr++; $display("[TB] FAIL rst_out_level_release: got %b expected %b", ro, 2'b00); end
    endtask

    task automatic test_errors;
        logic ack, err;
        logic [15:0] rd;
        logic [1:0] ro;
        // count is 4 here: two retrigger writes, zero-length pulse, level test pulse
        bus(1'b1, 16'h0200, 16'hFFFF, ack, err, rd, ro);
        nvec++; if (err !== 1'b1) begin nerr++; $display("[TB] FAIL err_write_ro: got %b expected %b", err, 1'b1); end
        nvec++; if (ack !== 1'b1) begin nerr++; $display("[TB] FAIL ack_write_ro: got %b expected %b", ack, 1'b1); end
        bus(1'b0, 16'h0200, 16'h0000, ack, err, rd, ro);
        nvec++; if (rd !== 16'hABCD) begin nerr++; $display("[TB] FAIL rd_systemid_unchanged: got %h expected %h", rd, 16'hABCD); end
        bus(1'b1, 16'h0206, 16'h0009, ack, err, rd, ro);
        nvec++; if (err !== 1'b1) begin nerr++; $display("[TB] FAIL err_write_num_rst: got %b expected %b", err, 1'b1); end
        bus(1'b0, 16'h0208, 16'h0000, ack, err, rd, ro);
        nvec++; if (err !== 1'b1) begin nerr++; $display("[TB] FAIL err_read_0208: got %b expected %b", err, 1'b1); end
        bus(1'b0, 16'h01FF, 16'h0000, ack, err, rd, ro);
        nvec++; if (err !== 1'b1) begin nerr++; $display("[TB] FAIL err_read_01ff: got %b expected %b", err, 1'b1); end
        bus(1'b1, 16'h0204, 16'h0000, ack, err, rd, ro);
        nvec++; if (err !== 1'b0) begin nerr++; $display("[TB] FAIL err_pulse_zero: got %b expected %b", err, 1'b0); end
        bus(1'b1, 16'h0204, 16'hFFFC, ack, err, rd, ro);
        idle(ro);
        nvec++; if (ro !== 2'b00) begin nerr++; $display("[TB] FAIL rst_out_masked_zero: got %b expected %b", ro, 2'b00); end
        bus(1'b0, 16'h0207, 16'h0000, ack, err, rd, ro);
        nvec++; if (rd !== 16'h0004) begin nerr++; $display("[TB] FAIL rd_count_unchanged: got %h expected %h", rd, 16'h0004); end
        bus(1'b1, 16'h0207, 16'hFFFF, ack, err, rd, ro);
        bus(1'b0, 16'h0207, 16'h0000, ack, err, rd, ro);
        nvec++; if (rd !== 16'h0000) begin nerr++; $display("[TB] FAIL rd_count_cleared: got %h expected %h", rd, 16'h0000); end
    endtask

    task automatic test_saturation;
        logic ack, err;
        logic [15:0] rd;
        logic [1:0] ro;
        bus(1'b1, 16'h0205, 16'h0001, ack, err, rd, ro);
        for (int i = 0; i < 65535; i++) begin
            bus(1'b1, 16'h0204, 16'h0001, ack, err, rd, ro);
        end
        bus(1'b0, 16'h0207, 16'h0000, ack, err, rd, ro);
        nvec++; if (rd !== 16'hFFFF) begin nerr++; $display("[TB] FAIL rd_count_65535: got %h expected %h", rd, 16'hFFFF); end
        bus(1'b1, 16'h0204, 16'h0002, ack, err, rd, ro);
        bus(1'b0, 16'h0207, 16'h0000, ack, err, rd, ro);
        nvec++; if (rd !== 16'hFFFF) begin nerr++; $display("[TB] FAIL rd_count_saturated: got %h expected %h", rd, 16'hFFFF); end
        bus(1'b1, 16'h0207, 16'h0000, ack, err, rd, ro);
        idle(ro);
    endtask

    task automatic test_rst_mid_pulse;
        logic ack, err;
        logic [15:0] rd;
        logic [1:0] ro;
        bus(1'b1, 16'h0205, 16'd10, ack, err, rd, ro);
        bus(1'b1, 16'h0204, 16'h0003, ack, err, rd, ro);
        for (int k = 0; k < 2; k++) begin
            idle(ro);
            nvec++; if (ro !== 2'b11) begin nerr++; $display("[TB] FAIL rst_out_pre_abort_c%0d: got %b expected %b", k, ro, 2'b11); end
        end
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            idle(ro);
            nvec++; if (ro !== 2'b11) begin nerr++; $display("[TB] FAIL rst_out_during_rst_c%0d: got %b expected %b", k, ro, 2'b11); end
        end
        rst = 1'b0;
        idle(ro);
        nvec++; if (ro !== 2'b00) begin nerr++; $display("[TB] FAIL rst_out_after_abort: got %b expected %b", ro, 2'b00); end
        bus(1'b0, 16'h0204, 16'h0000, ack, err, rd, ro);
        nvec++; if (rd !== 16'h0000) begin nerr++; $display("[TB] FAIL rd_pulse_after_abort: got %h expected %h", rd, 16'h0000); end
        bus(1'b0, 16'h0205, 16'h0000, ack, err, rd, ro);
        nvec++; if (rd !== 16'h0010) begin nerr++; $display("[TB] FAIL rd_pulse_len_after_abort: got %h expected %h", rd, 16'h0010); end
        for (int k = 0; k < 10; k++) begin
            idle(ro);
            nvec++; if (ro !== 2'b00) begin nerr++; $display("[TB] FAIL rst_out_no_resume_c%0d: got %b expected %b", k, ro, 2'b00); end
        end
    endtask

    initial begin
        rst         = 1'b1;
        reg_request = 1'b0;
        reg_write   = 1'b0;
        reg_addr    = 16'h0000;
        reg_size    = 2'b00;
        reg_wdata   = 16'h0000;
        @(posedge clk);
        #1;
        $display("[TB] starting osd_scm_rstctl tests");
        test_reset();
        test_level();
        test_pulse();
        test_retrigger();
        test_zero_length();
        test_level_over_pulse();
        test_errors();
        test_saturation();
        test_rst_mid_pulse();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
